// File: rtl/bus_dma_master.sv
// ============================================================================
// Module   : bus_dma_master
// Brief    : Single-master bus DMA initiator; copies LENGTH words src -> dst.
//            Optional constant-fill mode under macro BUS_DMA_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_dma_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
`ifdef BUS_DMA_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data_q;
  logic               busy_q;
  logic               done_q;
  logic               req_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  dout_q;
  logic               fill_q;

`ifndef BUS_DMA_FILL_EN
  assign fill_q = 1'b0;
`endif

  logic [LEN_W-1:0]   cnt_d;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_nxt_d;
  logic [ADDR_W-1:0]  wr_addr_nxt_d;
  logic               last_d;

  // Address sums are ADDR_W wide so they wrap naturally at the top of the map.
  assign cnt_d         = cnt_q + LEN_W'(1);
  assign rd_addr_d     = src_q + ADDR_W'(cnt_q);
  assign wr_addr_d     = dst_q + ADDR_W'(cnt_q);
  assign rd_addr_nxt_d = src_q + ADDR_W'(cnt_d);
  assign wr_addr_nxt_d = dst_q + ADDR_W'(cnt_d);
  assign last_d        = (cnt_d == len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
`ifdef BUS_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_q  <= 1'b0;
          wr_q   <= 1'b0;
          addr_q <= '0;
          dout_q <= '0;
          if (start) begin
            busy_q <= 1'b1;
            if (length == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              src_q   <= src_addr;
              dst_q   <= dst_addr;
              len_q   <= length;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
`ifdef BUS_DMA_FILL_EN
              fill_q  <= fill;
              data_q  <= fill_data;
`endif
            end
          end
        end

        S_REQ: begin
          if (m_grant) begin
            if (fill_q) begin
              wr_q    <= 1'b1;
              addr_q  <= wr_addr_d;
              dout_q  <= data_q;
              state_q <= S_WR;
            end else begin
              wr_q    <= 1'b0;
              addr_q  <= rd_addr_d;
              state_q <= S_RD_ADDR;
            end
          end
        end

        S_RD_ADDR: begin
          if (!m_grant) begin
            addr_q  <= '0;
            state_q <= S_REQ;
          end else begin
            state_q <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (!m_grant) begin
            addr_q  <= '0;
            state_q <= S_REQ;
          end else begin
            data_q  <= m_din;
            wr_q    <= 1'b1;
            addr_q  <= wr_addr_d;
            dout_q  <= m_din;
            state_q <= S_WR;
          end
        end

        S_WR: begin
          // A lost grant discards the word; the counter stays put so it is redone.
          if (!m_grant) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            state_q <= S_REQ;
          end else begin
            cnt_q <= cnt_d;
            if (last_d) begin
              req_q   <= 1'b0;
              wr_q    <= 1'b0;
              addr_q  <= '0;
              dout_q  <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (fill_q) begin
              addr_q  <= wr_addr_nxt_d;
              dout_q  <= data_q;
            end else begin
              wr_q    <= 1'b0;
              addr_q  <= rd_addr_nxt_d;
              dout_q  <= '0;
              state_q <= S_RD_ADDR;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          dout_q  <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          dout_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign m_req  = req_q;
  assign m_wr   = wr_q;
  assign m_addr = addr_q;
  assign m_dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_dma_master.sv
// ============================================================================
// Module   : tb_bus_dma_master
// Brief    : Directed self-checking bench for bus_dma_master with bus memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_dma_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;
`ifdef BUS_DMA_FILL_EN
  logic        fill;
  logic [63:0] fill_data;
`endif

  logic        gnt_block;
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [63:0] pl_data;
  logic [63:0] mem [0:65535];
  logic [15:0] wlog_a [$];
  logic [63:0] wlog_d [$];
  logic [15:0] rlog [$];
  int          done_cnt;
  int          req_cnt;
  int          n_pass;
  int          n_chk;
  int          tcyc;

  bus_dma_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_grant  (m_grant),
    .m_din    (m_din)
`ifdef BUS_DMA_FILL_EN
    ,
    .fill     (fill),
    .fill_data(fill_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_grant = m_req & ~gnt_block;

  // Bus memory: registered read data, writes only on granted write cycles.
  always @(posedge clk) begin
    if (m_req && m_grant && m_wr) begin
      mem[m_addr] <= m_dout;
      wlog_a.push_back(m_addr);
      wlog_d.push_back(m_dout);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
    if (m_req && m_grant && !m_wr && m_addr != 16'h0000) rlog.push_back(m_addr);
    m_din <= mem[m_addr];
    if (done) done_cnt <= done_cnt + 1;
    if (m_req) req_cnt <= req_cnt + 1;
  end

  task automatic rec(input string tag, input bit ok, input logic [63:0] obs);
    n_chk++;
    if (ok) n_pass++;
    else $error("FAIL %s: observed %h", tag, obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic poke(input logic [15:0] a, input logic [63:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
    src_addr = s;
    dst_addr = d;
    length = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    tcyc = 1;
  endtask

  task automatic wait_done();
    while (!done && tcyc < 300) tick();
  endtask

  initial begin
    int ws;
    int rs;
    int dc;
    int rc;
    n_pass = 0;
    n_chk = 0;
    tcyc = 0;
    done_cnt = 0;
    req_cnt = 0;
    reset_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    gnt_block = 1'b0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
`ifdef BUS_DMA_FILL_EN
    fill = 1'b0;
    fill_data = '0;
`endif
    tick();
    tick();
    rec("rst_busy", busy === 1'b0, 64'(busy));
    rec("rst_done", done === 1'b0, 64'(done));
    rec("rst_req", m_req === 1'b0, 64'(m_req));
    rec("rst_wr", m_wr === 1'b0, 64'(m_wr));
    rec("rst_addr", m_addr === 16'h0000, 64'(m_addr));
    rec("rst_dout", m_dout === 64'h0, m_dout);

    poke(16'h0010, 64'h11);
    poke(16'h0011, 64'h22);
    poke(16'h0012, 64'h33);
    poke(16'hFFFE, 64'hAAAA_0000_0000_FFFE);
    poke(16'hFFFF, 64'hBBBB_0000_0000_FFFF);
    poke(16'h0000, 64'hCCCC_0000_0000_0000);
    poke(16'h0040, 64'h1234_5678_9ABC_DEF0);
    poke(16'h0041, 64'h0FED_CBA9_8765_4321);
    reset_n = 1'b1;
    tick();

    // Reset during the second write cycle
    dc = done_cnt;
    go(16'h0000, 16'h0100, 8'd4);
    repeat (6) tick();
    rec("mid_wr2_wr", m_wr === 1'b1, 64'(m_wr));
    rec("mid_wr2_addr", m_addr === 16'h0101, 64'(m_addr));
    reset_n = 1'b0;
    #1;
    rec("mid_rst_busy", busy === 1'b0, 64'(busy));
    rec("mid_rst_done", done === 1'b0, 64'(done));
    rec("mid_rst_req", m_req === 1'b0, 64'(m_req));
    rec("mid_rst_wr", m_wr === 1'b0, 64'(m_wr));
    rec("mid_rst_addr", m_addr === 16'h0000, 64'(m_addr));
    rec("mid_rst_dout", m_dout === 64'h0, m_dout);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    rec("mid_idle_busy", busy === 1'b0, 64'(busy));
    rec("mid_idle_req", m_req === 1'b0, 64'(m_req));
    rec("mid_no_done", (done_cnt - dc) == 0, 64'(done_cnt - dc));

    // Basic copy, immediate grant
    ws = wlog_a.size();
    dc = done_cnt;
    go(16'h0010, 16'h0200, 8'd3);
    wait_done();
    rec("copy_latency", tcyc == 11, 64'(tcyc));
    rec("copy_req_at_done", m_req === 1'b0, 64'(m_req));
    rec("copy_nwr", (wlog_a.size() - ws) == 3, 64'(wlog_a.size() - ws));
    rec("copy_a0", wlog_a[ws] === 16'h0200, 64'(wlog_a[ws]));
    rec("copy_d0", wlog_d[ws] === 64'h11, wlog_d[ws]);
    rec("copy_a1", wlog_a[ws+1] === 16'h0201, 64'(wlog_a[ws+1]));
    rec("copy_d1", wlog_d[ws+1] === 64'h22, wlog_d[ws+1]);
    rec("copy_a2", wlog_a[ws+2] === 16'h0202, 64'(wlog_a[ws+2]));
    rec("copy_d2", wlog_d[ws+2] === 64'h33, wlog_d[ws+2]);
    tick();
    rec("copy_done_pulse", done === 1'b0, 64'(done));
    rec("copy_busy_after", busy === 1'b0, 64'(busy));
    rec("copy_done_once", (done_cnt - dc) == 1, 64'(done_cnt - dc));

    // Zero length
    rc = req_cnt;
    go(16'h0010, 16'h0600, 8'd0);
    rec("zero_done", done === 1'b1, 64'(done));
    rec("zero_req", m_req === 1'b0, 64'(m_req));
    tick();
    rec("zero_done_off", done === 1'b0, 64'(done));
    rec("zero_no_req", (req_cnt - rc) == 0, 64'(req_cnt - rc));

    // Address wrap on both ranges
    ws = wlog_a.size();
    go(16'hFFFE, 16'h7FFF, 8'd3);
    wait_done();
    rec("wrap_latency", tcyc == 11, 64'(tcyc));
    rec("wrap_nwr", (wlog_a.size() - ws) == 3, 64'(wlog_a.size() - ws));
    rec("wrap_a0", wlog_a[ws] === 16'h7FFF, 64'(wlog_a[ws]));
    rec("wrap_d0", wlog_d[ws] === 64'hAAAA_0000_0000_FFFE, wlog_d[ws]);
    rec("wrap_a1", wlog_a[ws+1] === 16'h8000, 64'(wlog_a[ws+1]));
    rec("wrap_d1", wlog_d[ws+1] === 64'hBBBB_0000_0000_FFFF, wlog_d[ws+1]);
    rec("wrap_a2", wlog_a[ws+2] === 16'h8001, 64'(wlog_a[ws+2]));
    rec("wrap_d2", wlog_d[ws+2] === 64'hCCCC_0000_0000_0000, wlog_d[ws+2]);
    tick();

    // Grant dropped for three cycles starting in RD_DATA of word 0
    ws = wlog_a.size();
    rs = rlog.size();
    go(16'h0040, 16'h0500, 8'd2);
    tick();
    rec("gd_rdaddr", m_addr === 16'h0040, 64'(m_addr));
    tick();
    gnt_block = 1'b1;
    rec("gd_rddata_hold", m_addr === 16'h0040, 64'(m_addr));
    tick();
    rec("gd_back_req", m_req === 1'b1, 64'(m_req));
    rec("gd_req_addr", m_addr === 16'h0000, 64'(m_addr));
    tick();
    tick();
    gnt_block = 1'b0;
    wait_done();
    rec("gd_latency", tcyc == 13, 64'(tcyc));
    rec("gd_nwr", (wlog_a.size() - ws) == 2, 64'(wlog_a.size() - ws));
    rec("gd_a0", wlog_a[ws] === 16'h0500, 64'(wlog_a[ws]));
    rec("gd_d0", wlog_d[ws] === 64'h1234_5678_9ABC_DEF0, wlog_d[ws]);
    rec("gd_a1", wlog_a[ws+1] === 16'h0501, 64'(wlog_a[ws+1]));
    rec("gd_d1", wlog_d[ws+1] === 64'h0FED_CBA9_8765_4321, wlog_d[ws+1]);
    rec("gd_nrd", (rlog.size() - rs) == 5, 64'(rlog.size() - rs));
    rec("gd_reread", rlog[rs+1] === 16'h0040, 64'(rlog[rs+1]));
    rec("gd_word1_rd", rlog[rs+3] === 16'h0041, 64'(rlog[rs+3]));
    tick();

`ifdef BUS_DMA_FILL_EN
    ws = wlog_a.size();
    rs = rlog.size();
    fill = 1'b1;
    fill_data = 64'hDEADBEEF_CAFEF00D;
    go(16'h0010, 16'h0300, 8'd4);
    fill = 1'b0;
    wait_done();
    rec("fill_latency", tcyc == 6, 64'(tcyc));
    rec("fill_nwr", (wlog_a.size() - ws) == 4, 64'(wlog_a.size() - ws));
    rec("fill_nrd", (rlog.size() - rs) == 0, 64'(rlog.size() - rs));
    for (int k = 0; k < 4; k++) begin
      rec("fill_addr", wlog_a[ws+k] === (16'h0300 + 16'(k)), 64'(wlog_a[ws+k]));
      rec("fill_data", wlog_d[ws+k] === 64'hDEADBEEF_CAFEF00D, wlog_d[ws+k]);
    end
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Bus initiator (master side) of the single-master system bus; drives m_req/m_wr/m_addr/m_dout and consumes m_grant/m_din.
- Performs block copies of LENGTH 64-bit words from a source address range to a destination address range, e.g. memory slave to factorial-core slave and back.
- Configured and started by the host/top-level controller through a start pulse.
- Reports busy and a one-cycle done pulse.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 64, bus data width.
- LEN_W, 8, width of the word-count field (max 255 words per transfer).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle start pulse; honoured only in IDLE.
- src_addr  input  ADDR_W  first source word address, sampled on accepted start.
- dst_addr  input  ADDR_W  first destination word address, sampled on accepted start.
- length  input  LEN_W  number of words to copy, sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- done  output  1  one-cycle pulse at transfer completion.
- m_req  output  1  bus request to the arbiter.
- m_wr  output  1  bus write strobe (1 = write, 0 = read).
- m_addr  output  ADDR_W  bus address.
- m_dout  output  DATA_W  write data to the bus.
- m_grant  input  1  arbiter grant.
- m_din  input  DATA_W  read data from the bus; valid the cycle after the read address cycle.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State is IDLE.
  - busy, done, m_req and m_wr are 0.
  - m_addr, m_dout, the word counter and the data holding register are 0.
  - Reset takes effect mid-transfer with no completion pulse.
- Outputs are registered.
- m_wr, m_addr and m_dout are driven only while granted; otherwise they are 0.
- IDLE:
  - start=1 with length=0: go to DONE with no bus request.
  - start=1 with length≠0: latch src, dst and length, clear counter i, assert m_req, go to REQ.
  - start in any other state is ignored.
- REQ: hold m_req=1; wait for m_grant=1, then go to RD_ADDR.
- RD_ADDR (1 cycle): m_wr=0, m_addr=src+i; go to RD_DATA.
- RD_DATA (1 cycle): hold m_addr; capture m_din into the data register at the end of the cycle; go to WR.
- WR (1 cycle):
  - m_wr=1, m_addr=dst+i, m_dout=captured data.
  - i increments.
  - If i+1==length, go to DONE; otherwise go to RD_ADDR.
- DONE (1 cycle): m_req=0, m_wr=0, done=1, busy=0 on exit; go to IDLE.
- Throughput: 3 cycles per word once granted.
- Total latency from start to done pulse: 1 + grant wait + 3·length + 1 cycles.
- Address arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000.
- Grant loss: if m_grant falls in RD_ADDR, RD_DATA or WR, the block returns to REQ with m_req held high. The current word restarts from RD_ADDR once re-granted; i is not advanced and the partial word is discarded.
- Overlapping src/dst ranges: words are copied in ascending order with no hazard protection.

Optional Feature:
- Macro BUS_DMA_FILL_EN.
- When defined, two extra inputs are present:
  - fill (1 bit): sampled with start.
  - fill_data (DATA_W): sampled with start.
- With fill=1 the block skips RD_ADDR/RD_DATA and writes fill_data to dst+i each word, at 1 cycle per word after grant.
- When the macro is undefined, the ports are absent and every transfer is a copy.

Test Plan:
- Reset mid-transfer: start src=0x0000, dst=0x0100, len=4; pull reset_n low during the 2nd WR -> all outputs 0 immediately, no done pulse, state IDLE after release.
- Basic copy: memory model with mem[0x0010..0x0012]=0x11,0x22,0x33; start src=0x0010, dst=0x0200, len=3; grant 1 cycle after req -> mem[0x0200..0x0202]=0x11,0x22,0x33; done pulses exactly 11 cycles after start; m_req low on the done cycle.
- Zero length: start len=0 -> m_req never asserted; done pulses the next cycle.
- Address wrap: start src=0xFFFE, dst=0x7FFF, len=3 -> reads hit 0xFFFE, 0xFFFF, 0x0000; writes hit 0x7FFF, 0x8000, 0x8001.
- Grant drop: len=2; deassert m_grant for 3 cycles during RD_DATA of word 0 -> word 0 re-read from src+0 after re-grant; both destination words correct; no duplicate or skipped writes.
- Fill (BUS_DMA_FILL_EN): start fill=1, fill_data=0xDEADBEEF_CAFEF00D, dst=0x0300, len=4 -> four writes with that value; no read cycles on the bus; done pulses 6 cycles after start with immediate grant.
